// File: rtl/spi_master_multi.sv
// SPI master for the DAC control path: runtime CPOL/CPHA/bit order/divider,
// multiple chip selects with automatic CS timing and optional CS hold between frames.
module spi_master_multi #(
  parameter int DATA_W = 16,
  parameter int CS_NUM = 2,
  parameter int DIV_W  = 16,
  parameter int CS_W   = (CS_NUM > 1) ? $clog2(CS_NUM) : 1
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cs_hold,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic [CS_NUM-1:0] nCS,
  output logic              DCLK,
  output logic              MOSI,
  input  logic              MISO
);

  localparam int EDGE_W = $clog2(2 * DATA_W + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SWITCH, ST_SETUP, ST_WAIT, ST_HOLD, ST_GAP, ST_DONE
  } state_t;

  state_t              state_q;
  logic [DIV_W-1:0]    cnt_q, div_q;
  logic [EDGE_W-1:0]   edge_q;
  logic                cpha_q, lsb_q, hold_q;
  logic [CS_W-1:0]     sel_q, held_idx_q;
  logic                held_q;
  logic [DATA_W-1:0]   tx_sh_q, rx_sh_q, rx_data_q;
  logic                rx_valid_q, tx_ready_q, dclk_q, mosi_q;
  logic [CS_NUM-1:0]   ncs_q;

  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
    for (int i = 0; i < DATA_W; i++) bit_rev[i] = v[DATA_W-1-i];
  endfunction

  // An out-of-range select matches no bit, so the frame runs with every CS high.
  function automatic logic [CS_NUM-1:0] cs_decode(input logic [CS_W-1:0] sel);
    cs_decode = '1;
    for (int i = 0; i < CS_NUM; i++) if (sel == CS_W'(i)) cs_decode[i] = 1'b0;
  endfunction

  // Frames are always shifted MSB-first internally; lsb_first just reverses the word.
  logic [DATA_W-1:0] tx_ord;
  logic              half_done, edge_odd, do_sample, do_shift, last_edge;

  assign tx_ord    = lsb_first ? bit_rev(tx_data) : tx_data;
  assign half_done = (cnt_q == '0);
  assign edge_odd  = ~edge_q[0];
  assign do_sample = edge_odd ^ cpha_q;
  assign do_shift  = cpha_q ? (edge_odd && edge_q >= EDGE_W'(2))
                            : (!edge_odd && edge_q < EDGE_W'(2 * DATA_W - 2));
  assign last_edge = (edge_q == EDGE_W'(2 * DATA_W - 1));

  always_ff @(posedge sys_clk or posedge rst) begin
    // NOTE: the shift registers are reset along with the control state so that
    // an aborted frame leaves nothing behind that could leak into rx_data later.
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      edge_q     <= '0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      hold_q     <= 1'b0;
      sel_q      <= '0;
      held_idx_q <= '0;
      held_q     <= 1'b0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b1;
      dclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      ncs_q      <= '1;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below reads
      // the pre-edge register values regardless of statement order.
      rx_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          dclk_q <= cpol;
          if (tx_valid && tx_ready_q) begin
            tx_ready_q <= 1'b0;
            cpha_q     <= cpha;
            lsb_q      <= lsb_first;
            div_q      <= clk_div;
            sel_q      <= cs_sel;
            hold_q     <= cs_hold;
            cnt_q      <= clk_div;
            edge_q     <= '0;
            tx_sh_q    <= tx_ord;
            mosi_q     <= tx_ord[DATA_W-1];
            if (held_q && held_idx_q != cs_sel) begin
              ncs_q   <= '1;
              state_q <= ST_SWITCH;
            end else if (held_q) begin
              state_q <= ST_WAIT;
            end else begin
              ncs_q   <= cs_decode(cs_sel);
              state_q <= ST_SETUP;
            end
          end
        end
        ST_SWITCH: begin
          if (half_done) begin
            cnt_q   <= div_q;
            ncs_q   <= cs_decode(sel_q);
            state_q <= ST_SETUP;
          end else cnt_q <= cnt_q - 1'b1;
        end
        ST_SETUP, ST_WAIT: begin
          if (half_done) begin
            cnt_q  <= div_q;
            dclk_q <= ~dclk_q;
            edge_q <= edge_q + 1'b1;
            if (do_sample) rx_sh_q <= {rx_sh_q[DATA_W-2:0], MISO};
            if (do_shift) begin
              tx_sh_q <= {tx_sh_q[DATA_W-2:0], 1'b0};
              mosi_q  <= tx_sh_q[DATA_W-2];
            end
            state_q <= last_edge ? ST_HOLD : ST_WAIT;
          end else cnt_q <= cnt_q - 1'b1;
        end
        ST_HOLD: begin
          if (half_done) begin
            cnt_q <= div_q;
            if (hold_q) begin
              held_q     <= 1'b1;
              held_idx_q <= sel_q;
              rx_valid_q <= 1'b1;
              rx_data_q  <= lsb_q ? bit_rev(rx_sh_q) : rx_sh_q;
              state_q    <= ST_DONE;
            end else begin
              held_q  <= 1'b0;
              ncs_q   <= '1;
              state_q <= ST_GAP;
            end
          end else cnt_q <= cnt_q - 1'b1;
        end
        ST_GAP: begin
          if (half_done) begin
            rx_valid_q <= 1'b1;
            rx_data_q  <= lsb_q ? bit_rev(rx_sh_q) : rx_sh_q;
            state_q    <= ST_DONE;
          end else cnt_q <= cnt_q - 1'b1;
        end
        ST_DONE: begin
          tx_ready_q <= 1'b1;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_ready = tx_ready_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign busy     = (state_q != ST_IDLE);
  assign nCS      = ncs_q;
  assign DCLK     = dclk_q;
  assign MOSI     = mosi_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi: a table of frames with hand-computed timing,
// plus a mid-frame reset sequence. A behavioural slave drives MISO from DCLK edges.
module tb_spi_master_multi;

  localparam int DW  = 16;
  localparam int CSN = 3;

  logic            sys_clk = 1'b0;
  logic            rst;
  logic            cpol, cpha, lsb_first, cs_hold, tx_valid;
  logic [15:0]     clk_div;
  logic [1:0]      cs_sel;
  logic            tx_ready, rx_valid, busy, dclk, mosi, miso;
  logic [DW-1:0]   tx_data, rx_data;
  logic [CSN-1:0]  ncs;

  logic            loopback, slv_bit;
  int              cyc = 0;
  int              n_checks = 0;
  int              n_errors = 0;
  logic [DW-1:0]   prev_rx;

  spi_master_multi #(.DATA_W(DW), .CS_NUM(CSN), .DIV_W(16)) dut (
    .sys_clk(sys_clk), .rst(rst), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
    .clk_div(clk_div), .cs_sel(cs_sel), .cs_hold(cs_hold), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_data(tx_data), .rx_valid(rx_valid), .rx_data(rx_data),
    .busy(busy), .nCS(ncs), .DCLK(dclk), .MOSI(mosi), .MISO(miso)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;
  assign miso = loopback ? mosi : slv_bit;

  typedef struct {
    logic        cpol, cpha, lsb;
    logic [15:0] div;
    logic [1:0]  sel;
    logic        hold, loop, mutate;
    logic [15:0] tx, pat, rx;
    int          len, first, hi;
    logic [2:0]  ncs;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Bit index the link is on after e DCLK toggles, for the given phase.
  function automatic int bit_idx(input int e, input logic ph);
    int idx;
    idx = ph ? ((e > 0) ? (e - 1) / 2 : 0) : e / 2;
    return (idx > DW - 1) ? DW - 1 : idx;
  endfunction

  task automatic run_frame(input string tag, input vec_t v, input int abort_edge);
    logic [DW-1:0] lat_tx;
    logic          lat_cpol, lat_cpha, lat_lsb, done, dclk_prev, mutated, exp_mosi;
    logic [2:0]    ncs_edge;
    int            c0, c1, tog, first_cyc, last_cyc, hi, mosi_err, viol, idx, h, pulses;
    @(negedge sys_clk);
    cpol = v.cpol; cpha = v.cpha; lsb_first = v.lsb; clk_div = v.div;
    cs_sel = v.sel; cs_hold = v.hold; tx_data = v.tx; loopback = v.loop; slv_bit = 1'b0;
    @(negedge sys_clk);
    check({tag, "_idle_dclk"}, dclk, v.cpol);
    check({tag, "_idle_ready"}, tx_ready, 1);
    check({tag, "_rx_hold"}, rx_data, prev_rx);
    lat_tx = v.tx; lat_cpol = v.cpol; lat_cpha = v.cpha; lat_lsb = v.lsb;
    h = int'(v.div) + 1;
    tog = 0; first_cyc = 0; last_cyc = 0; mosi_err = 0; viol = 0; done = 1'b0;
    mutated = 1'b0; ncs_edge = '0; c1 = 0;
    dclk_prev = dclk;
    hi = (ncs == 3'b111) ? 1 : 0;
    idx = bit_idx(0, lat_cpha);
    slv_bit = lat_lsb ? v.pat[idx] : v.pat[DW-1-idx];
    tx_valid = 1'b1;
    c0 = cyc;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge sys_clk);
      if (k == 0) begin
        tx_valid = 1'b0;
        check({tag, "_ready_drop"}, tx_ready, 0);
      end
      if (dclk != dclk_prev) begin
        tog++;
        if (tog == 1) begin
          first_cyc = cyc;
          ncs_edge  = ncs;
        end
        last_cyc = cyc;
      end
      dclk_prev = dclk;
      if (v.mutate && tog == 5 && !mutated) begin
        tx_data = ~tx_data;
        cpol    = ~cpol;
        mutated = 1'b1;
      end
      idx = bit_idx(tog, lat_cpha);
      slv_bit  = lat_lsb ? v.pat[idx] : v.pat[DW-1-idx];
      exp_mosi = lat_lsb ? lat_tx[idx] : lat_tx[DW-1-idx];
      if (busy && mosi !== exp_mosi) mosi_err++;
      if (ncs == 3'b111) hi++;
      if ($countones(~ncs) > 1) viol++;
      if (abort_edge != 0 && tog == abort_edge) begin
        check({tag, "_pre_rst_dclk"}, dclk, 1);
        rst = 1'b1;
        #1;
        check({tag, "_rst_ncs"}, ncs, 3'b111);
        check({tag, "_rst_dclk"}, dclk, 0);
        check({tag, "_rst_busy"}, busy, 0);
        check({tag, "_rst_rxv"}, rx_valid, 0);
        check({tag, "_rst_ready"}, tx_ready, 1);
        check({tag, "_rst_mosi"}, mosi, 0);
        @(negedge sys_clk);
        rst = 1'b0;
        pulses = 0;
        for (int j = 0; j < 8; j++) begin
          @(negedge sys_clk);
          if (rx_valid) pulses++;
        end
        check({tag, "_rst_no_rxv"}, pulses, 0);
        prev_rx = '0;
        return;
      end
      if (rx_valid) begin
        done = 1'b1;
        c1   = cyc;
      end
    end
    check({tag, "_timeout"}, done, 1);
    check({tag, "_rx_data"}, rx_data, v.rx);
    check({tag, "_len"}, c1 - c0 + 1, v.len);
    check({tag, "_first_edge"}, first_cyc - c0, v.first);
    check({tag, "_edges"}, tog, 2 * DW);
    check({tag, "_spacing"}, last_cyc - first_cyc, (2 * DW - 1) * h);
    check({tag, "_ncs"}, ncs_edge, v.ncs);
    check({tag, "_ncs_high_cyc"}, hi, v.hi);
    check({tag, "_ncs_onehot"}, viol, 0);
    check({tag, "_mosi"}, mosi_err, 0);
    check({tag, "_done_dclk"}, dclk, lat_cpol);
    @(negedge sys_clk);
    check({tag, "_rxv_pulse"}, rx_valid, 0);
    check({tag, "_ready_back"}, tx_ready, 1);
    prev_rx = v.rx;
  endtask

  initial begin
    vec_t rst_vec;
    //                cpol  cpha  lsb   div  sel   hold  loop  mut   tx        pat       rx        len  1st  hi  ncs
    vecs[0] = '{1'b0, 1'b0, 1'b0, 16'd1, 2'd0, 1'b0, 1'b1, 1'b0, 16'hA5C3, 16'h0000, 16'hA5C3,  70,  3,  4, 3'b110};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 16'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0001, 16'h8000, 16'h8000,  36,  2,  3, 3'b110};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 16'd2, 2'd1, 1'b1, 1'b1, 1'b0, 16'h1234, 16'h0000, 16'h1234, 101,  4,  1, 3'b101};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 16'd1, 2'd1, 1'b0, 1'b1, 1'b0, 16'h5678, 16'h0000, 16'h5678,  70,  3,  3, 3'b101};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 16'd0, 2'd0, 1'b1, 1'b0, 1'b0, 16'h00FF, 16'h3C3C, 16'h3C3C,  35,  2,  1, 3'b110};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 16'd1, 2'd1, 1'b0, 1'b1, 1'b0, 16'hF00F, 16'h0000, 16'hF00F,  72,  5,  5, 3'b101};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 16'd0, 2'd3, 1'b0, 1'b1, 1'b0, 16'h8001, 16'h0000, 16'h8001,  36,  2, 36, 3'b111};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 16'd1, 2'd2, 1'b0, 1'b1, 1'b1, 16'h0F0F, 16'h0000, 16'h0F0F,  70,  3,  4, 3'b011};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 16'd0, 2'd0, 1'b1, 1'b1, 1'b0, 16'h1357, 16'h0000, 16'h1357,  35,  2,  1, 3'b110};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 16'd1, 2'd1, 1'b0, 1'b1, 1'b0, 16'h2468, 16'h0000, 16'h2468,  70,  3,  4, 3'b101};
    rst_vec = '{1'b0, 1'b0, 1'b0, 16'd0, 2'd0, 1'b1, 1'b1, 1'b0, 16'h9999, 16'h0000, 16'h0000,   0,  0,  0, 3'b110};

    rst = 1'b1; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; clk_div = '0; cs_sel = '0;
    cs_hold = 1'b0; tx_valid = 1'b0; tx_data = 16'hFFFF; loopback = 1'b1; slv_bit = 1'b0;
    prev_rx = '0;
    #1;
    check("reset_ncs", ncs, 3'b111);
    check("reset_dclk", dclk, 0);
    check("reset_mosi", mosi, 0);
    check("reset_ready", tx_ready, 1);
    check("reset_rxv", rx_valid, 0);
    check("reset_rxdata", rx_data, 0);
    check("reset_busy", busy, 0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_frame($sformatf("v%0d", i), vecs[i], 0);

    // Held CS on sel 0, reset at edge 9 of a held frame, then a clean frame on sel 1
    // must start without a CS switch because reset cleared the held flag.
    run_frame("v8", vecs[8], 0);
    run_frame("rst", rst_vec, 9);
    run_frame("v9", vecs[9], 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
